rgb_led_pwm: RTL and testbench

CPU-bus peripheral on the 6502 data bus that generates three PWM streams, with an optional "breathing" brightness envelope. Its pwm_o[2:0] outputs feed the RGB0PWM/RGB1PWM/RGB2PWM inputs of the top-level SB_RGBA_DRV, replacing the raw gpio_o[7:5] bits. Duty writes are double-buffered so the LED outputs never glitch mid-period.

---
 rtl/rgb_led_pwm.sv | 128 ++++++++++++
 tb/tb_rgb_led_pwm.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rgb_led_pwm.sv
// rtl/rgb_led_pwm.sv - three-channel CPU-bus PWM for the RGB LED driver with breathing envelope
module rgb_led_pwm #(
    parameter int CH = 3,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          we,
    input  logic [2:0]    addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic [CH-1:0] pwm_o,
    output logic          wrap
);

    localparam logic [PW-1:0] ONE = 1;

    logic [1:0]      ctrl;
    logic [PW-1:0]   duty [CH];
    logic [PW-1:0]   active [CH];
    logic [PW-1:0]   eff [CH];
    logic [2*PW-1:0] prod [CH];
    logic [7:0]      presc;
    logic [7:0]      brate;
    logic [7:0]      breath_cnt;
    logic [7:0]      prescaler;
    logic [PW-1:0]   counter;
    logic [PW-1:0]   level;
    logic            dir_down;
    logic            en;
    logic            breathe;
    logic            tick;
    logic            eop;

    assign en      = ctrl[0];
    assign breathe = ctrl[1];
    assign tick    = en && (prescaler == presc);
    assign eop     = tick && (counter == '1);

    // Breathing scales each duty by the level held before this edge's step.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            prod[i] = {{PW{1'b0}}, duty[i]} * {{PW{1'b0}}, level};
            eff[i]  = breathe ? prod[i][2*PW-1:PW] : duty[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl       <= '0;
            presc      <= '0;
            brate      <= '0;
            breath_cnt <= '0;
            prescaler  <= '0;
            counter    <= '0;
            level      <= '0;
            dir_down   <= 1'b0;
            dout       <= '0;
            wrap       <= 1'b0;
            pwm_o      <= '0;
            for (int i = 0; i < CH; i++) begin
                duty[i]   <= '0;
                active[i] <= '0;
            end
        end else begin
            if (cs && we) begin
                case (addr)
                    3'd0: ctrl    <= din[1:0];
                    3'd1: duty[0] <= din[PW-1:0];
                    3'd2: duty[1] <= din[PW-1:0];
                    3'd3: duty[2] <= din[PW-1:0];
                    3'd4: presc   <= din;
                    3'd5: brate   <= din;
                    default: ;
                endcase
            end

            if (cs && !we) begin
                case (addr)
                    3'd0: dout <= {6'b0, ctrl};
                    3'd1: dout <= 8'(duty[0]);
                    3'd2: dout <= 8'(duty[1]);
                    3'd3: dout <= 8'(duty[2]);
                    3'd4: dout <= presc;
                    3'd5: dout <= brate;
                    3'd6: dout <= 8'(level);
                    default: dout <= 8'(counter);
                endcase
            end

            if (!en) begin
                prescaler <= '0;
                counter   <= '0;
            end else if (tick) begin
                prescaler <= '0;
                counter   <= counter + ONE;
            end else begin
                prescaler <= prescaler + 8'd1;
            end

            // Shadow duties only reach the outputs at a period boundary, so no mid-period glitches.
            for (int i = 0; i < CH; i++) begin
                if (!en || eop)
                    active[i] <= eff[i];
                pwm_o[i] <= en && (counter < active[i]);
            end

            wrap <= eop;

            if (eop && breathe) begin
                if (breath_cnt == brate) begin
                    breath_cnt <= '0;
                    if (!dir_down) begin
                        if (level == '1) dir_down <= 1'b1;
                        level <= (level == '1) ? level - ONE : level + ONE;
                    end else begin
                        if (level == '0) dir_down <= 1'b0;
                        level <= (level == '0) ? level + ONE : level - ONE;
                    end
                end else begin
                    breath_cnt <= breath_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// tb/tb_rgb_led_pwm.sv - scoreboard bench for rgb_led_pwm
`timescale 1ns/1ps
module tb_rgb_led_pwm;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [2:0] pwm_o;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int hi0;
        int hi1;
        int hi2;
        int wr;
    } win_t;

    win_t       win_q[$];
    logic [7:0] rd_q[$];

    rgb_led_pwm #(.CH(3), .PW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .pwm_o (pwm_o),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [7:0] e, input string tag);
        rd_q.push_back(e);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        cs = 1'b0;
        check(tag, dout, rd_q.pop_front());
    endtask

    task automatic wait_wrap(input string tag);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (wrap) break;
        end
        if (k == 5000) check(tag, 0, 1);
    endtask

    // Counts output activity over n clocks; optionally issues one bus op at clock op_at.
    task automatic run_window(input int n, input int op_at, input logic op_we,
                              input logic [2:0] op_addr, input logic [7:0] op_din,
                              input string tag);
        int   h0 = 0, h1 = 0, h2 = 0, w = 0;
        win_t e;
        for (int k = 0; k < n; k++) begin
            h0 += int'(pwm_o[0]);
            h1 += int'(pwm_o[1]);
            h2 += int'(pwm_o[2]);
            w  += int'(wrap);
            if (!op_we && op_at >= 0 && k == op_at + 1)
                check({tag, "_rd"}, dout, rd_q.pop_front());
            cs = 1'b0; we = 1'b0;
            if (k == op_at) begin
                cs = 1'b1; we = op_we; addr = op_addr; din = op_din;
            end
            @(negedge clk);
        end
        e = win_q.pop_front();
        check({tag, "_hi0"}, h0, e.hi0);
        check({tag, "_hi1"}, h1, e.hi1);
        check({tag, "_hi2"}, h2, e.hi2);
        check({tag, "_wrap"}, w, e.wr);
    endtask

    initial begin
        int  lvl;
        int  prev;
        bit  up;

        reset = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_o, 0);
        check("rst_wrap", wrap, 0);
        check("rst_dout", dout, 0);
        reset = 1'b1;
        for (int a = 0; a < 8; a++) rd_reg(3'(a), 8'h00, "rst_rd");

        wr_reg(3'd4, 8'd0);
        wr_reg(3'd1, 8'd64);
        wr_reg(3'd2, 8'd0);
        wr_reg(3'd3, 8'd255);
        wr_reg(3'd6, 8'h55);
        wr_reg(3'd7, 8'h55);
        rd_reg(3'd1, 8'd64, "rb_duty0");
        rd_reg(3'd3, 8'd255, "rb_duty2");
        rd_reg(3'd6, 8'd0, "ro_level");
        rd_reg(3'd7, 8'd0, "ro_cnt");
        wr_reg(3'd0, 8'h01);
        rd_reg(3'd0, 8'h01, "rb_ctrl");
        @(negedge clk);
        check("dout_hold", dout, 1);

        wait_wrap("wrap_p0");
        for (int r = 0; r < 2; r++) begin
            win_q.push_back('{64, 0, 255, 1});
            run_window(256, -1, 1'b0, 3'd0, 8'd0, "p0");
        end

        wr_reg(3'd4, 8'd3);
        wait_wrap("wrap_p3");
        win_q.push_back('{256, 0, 1020, 1});
        run_window(1024, 300, 1'b1, 3'd1, 8'd128, "p3_mid");
        win_q.push_back('{512, 0, 1020, 1});
        run_window(1024, 1023, 1'b1, 3'd1, 8'h40, "p3_new");
        win_q.push_back('{512, 0, 1020, 1});
        run_window(1024, -1, 1'b0, 3'd0, 8'd0, "p3_eopwr");
        win_q.push_back('{256, 0, 1020, 1});
        run_window(1024, -1, 1'b0, 3'd0, 8'd0, "p3_after");

        repeat (10) @(negedge clk);
        check("pre_rst_pwm0", pwm_o[0], 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("mid_rst_pwm", pwm_o, 0);
        check("mid_rst_wrap", wrap, 0);
        rd_reg(3'd6, 8'd0, "mid_rst_level");
        rd_reg(3'd7, 8'd0, "mid_rst_cnt");
        rd_reg(3'd0, 8'd0, "mid_rst_ctrl");
        win_q.push_back('{0, 0, 0, 0});
        run_window(600, -1, 1'b0, 3'd0, 8'd0, "post_rst");

        wr_reg(3'd5, 8'd0);
        wr_reg(3'd1, 8'd200);
        wr_reg(3'd0, 8'h03);
        wait_wrap("wrap_br");
        lvl = 0;
        up  = 1'b1;
        for (int p = 0; p < 258; p++) begin
            prev = lvl;
            if (up) begin
                if (lvl == 255) begin up = 1'b0; lvl = 254; end
                else lvl = lvl + 1;
            end else begin
                if (lvl == 0) begin up = 1'b1; lvl = 1; end
                else lvl = lvl - 1;
            end
            rd_q.push_back(8'(lvl));
            win_q.push_back('{(200 * prev) >> 8, 0, 0, 1});
            run_window(256, 0, 1'b0, 3'd6, 8'd0, "breath");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
